// File: rtl/uart_rx_ext_pkg.sv
// Shared definitions for the extended UART receiver: FSM states, parity modes, sizing helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_rx_ext_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam int PAR_EVEN = 0;
   localparam int PAR_ODD  = 1;

   // Bits needed to hold values 0..v-1, never less than 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_rx_ext_if.sv
// Receiver result bus: done strobe, received word, error flags and busy indication.
// Latency: n/a (wiring only).
// Backpressure: none; consumer must take the word on the done strobe or from the held outputs.
// Ports: o_rx_done_tick, o_data_out[DBIT], o_parity_err, o_frame_err, o_break, o_busy.
interface uart_rx_ext_if #(
   parameter int DBIT = 8
);
   logic            o_rx_done_tick;
   logic [DBIT-1:0] o_data_out;
   logic            o_parity_err;
   logic            o_frame_err;
   logic            o_break;
   logic            o_busy;

   modport master (
      output o_rx_done_tick, o_data_out, o_parity_err, o_frame_err, o_break, o_busy
   );

   modport slave (
      input o_rx_done_tick, o_data_out, o_parity_err, o_frame_err, o_break, o_busy
   );
endinterface

// File: rtl/uart_rx_ext_sampler.sv
// Oversampling tick counter with 3-sample capture and majority vote for one bit period.
// Latency: vote/done strobes are combinational on the terminal tick; the counter wraps to 0 there.
// Backpressure: none; advances only on i_tick, held at 0 while i_clr.
// Ports: i_clk, i_reset, i_clr (hold count at 0), i_tick, i_rx_s (synchronised line),
//        i_tc (terminal count), o_maj (vote incl. current sample), o_vote_pt (3rd sample tick), o_done.
module uart_rx_ext_sampler #(
   parameter int OSR = 16,
   parameter int SW  = 4
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_clr,
   input  logic          i_tick,
   input  logic          i_rx_s,
   input  logic [SW-1:0] i_tc,
   output logic          o_maj,
   output logic          o_vote_pt,
   output logic          o_done
);
   localparam logic [SW-1:0] S_V0 = SW'(OSR - 3);
   localparam logic [SW-1:0] S_V1 = SW'(OSR - 2);
   localparam logic [SW-1:0] S_V2 = SW'(OSR - 1);

   logic [SW-1:0] r_s;
   logic          r_smp0;
   logic          r_smp1;
   logic          w_tick;

   assign w_tick = i_tick & ~i_clr;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s    <= '0;
         r_smp0 <= 1'b0;
         r_smp1 <= 1'b0;
      end else if (i_clr) begin
         r_s <= '0;
      end else if (i_tick) begin
         r_s <= (r_s == i_tc) ? '0 : r_s + SW'(1);
         if (r_s == S_V0) r_smp0 <= i_rx_s;
         if (r_s == S_V1) r_smp1 <= i_rx_s;
      end
   end

   // Third sample is the live line value, so the vote is ready on the same tick.
   assign o_maj     = (r_smp0 & r_smp1) | (r_smp0 & i_rx_s) | (r_smp1 & i_rx_s);
   assign o_vote_pt = w_tick & (r_s == S_V2);
   assign o_done    = w_tick & (r_s == i_tc);

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: synchroniser, majority-voted bits, optional parity, break detect.
// Latency: SYNC_STAGES clocks on the line; result registered one clock after the stop terminal tick.
// Backpressure: none; results hold until the next frame's done strobe.
// Ports: i_clk, i_reset (sync, active-high), i_rx (async line, idle high), i_s_tick, o_rx (result bus).
module uart_rx_ext
   import uart_rx_ext_pkg::*;
#(
   parameter int DBIT        = 8,
   parameter int OSR         = 16,
   parameter int SB_TICK     = 16,
   parameter int PARITY_EN   = 0,
   parameter int PARITY_ODD  = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_rx,
   input  logic           i_s_tick,
   uart_rx_ext_if.master  o_rx
);
   localparam int SW = clog2(max_int(OSR, SB_TICK));
   localparam int NW = clog2(DBIT);
   localparam logic [SW-1:0] S_START_END = SW'(OSR / 2 - 1);
   localparam logic [SW-1:0] S_BIT_END   = SW'(OSR - 1);
   localparam logic [SW-1:0] S_STOP_END  = SW'(SB_TICK - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   state_t                 r_state, w_state_nxt;
   logic [NW-1:0]          r_n;
   logic [DBIT-1:0]        r_buf, r_data_out;
   logic                   r_pbit, r_stop, r_armed;
   logic                   r_done, r_perr, r_ferr, r_break;
   logic                   w_rx_s, w_clr, w_shift, w_pcap, w_scap, w_frame_end;
   logic                   w_maj, w_vote_pt, w_done, w_last, w_stop_bit;
   logic                   w_perr, w_ferr, w_brk;
   logic [SW-1:0]          w_tc;

   assign w_rx_s = r_sync[SYNC_STAGES-1];

   uart_rx_ext_sampler #(.OSR(OSR), .SW(SW)) u_sampler (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clr     (w_clr),
      .i_tick    (i_s_tick),
      .i_rx_s    (w_rx_s),
      .i_tc      (w_tc),
      .o_maj     (w_maj),
      .o_vote_pt (w_vote_pt),
      .o_done    (w_done)
   );

   assign w_last = (r_n == NW'(DBIT - 1));
   // With 1-stop framing the stop vote and frame end land on the same tick.
   assign w_stop_bit = w_vote_pt ? w_maj : r_stop;
   assign w_perr = (PARITY_EN != 0) && ((^r_buf) ^ r_pbit ^ (PARITY_ODD == PAR_ODD));
   assign w_ferr = ~w_stop_bit;
   assign w_brk  = w_ferr && (r_buf == '0) && ((PARITY_EN == 0) || !r_pbit);

   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_tc        = S_BIT_END;
      w_shift     = 1'b0;
      w_pcap      = 1'b0;
      w_scap      = 1'b0;
      w_frame_end = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_clr = 1'b1;
            if (!w_rx_s && r_armed) w_state_nxt = ST_START;
         end
         ST_START: begin
            w_tc = S_START_END;
            if (w_done) w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (w_done) begin
               w_shift = 1'b1;
               if (w_last) w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (w_done) begin
               w_pcap      = 1'b1;
               w_state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            w_tc   = S_STOP_END;
            w_scap = w_vote_pt;
            if (w_done) begin
               w_frame_end = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync     <= '1;
         r_state    <= ST_IDLE;
         r_n        <= '0;
         r_buf      <= '0;
         r_pbit     <= 1'b0;
         r_stop     <= 1'b0;
         r_armed    <= 1'b1;
         r_done     <= 1'b0;
         r_data_out <= '0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         r_break    <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], i_rx};
         r_state <= w_state_nxt;
         r_done  <= w_frame_end;
         if (w_shift) begin
            r_buf <= {w_maj, r_buf[DBIT-1:1]};
            r_n   <= w_last ? '0 : r_n + NW'(1);
         end
         if (w_pcap) r_pbit <= w_maj;
         if (w_scap) r_stop <= w_maj;
         if (w_frame_end) begin
            r_data_out <= r_buf;
            r_perr     <= w_perr;
            r_ferr     <= w_ferr;
            r_break    <= w_brk;
            // A held-low line after a bad stop must go high before a new start counts.
            r_armed    <= ~w_ferr;
         end else if (r_state == ST_IDLE && w_rx_s) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign o_rx.o_rx_done_tick = r_done;
   assign o_rx.o_data_out     = r_data_out;
   assign o_rx.o_parity_err   = r_perr;
   assign o_rx.o_frame_err    = r_ferr;
   assign o_rx.o_break        = r_break;
   assign o_rx.o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: three configurations driven with directed and random frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_ext;

   typedef struct packed {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       s_tick;
   logic [2:0] rx;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt [3] = '{0, 0, 0};

   uart_rx_ext_if #(.DBIT(8)) bus0 ();
   uart_rx_ext_if #(.DBIT(8)) bus1 ();
   uart_rx_ext_if #(.DBIT(7)) bus2 ();

   uart_rx_ext dut0 (
      .i_clk(clk), .i_reset(reset), .i_rx(rx[0]), .i_s_tick(s_tick), .o_rx(bus0)
   );
   uart_rx_ext #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
      .i_clk(clk), .i_reset(reset), .i_rx(rx[1]), .i_s_tick(s_tick), .o_rx(bus1)
   );
   uart_rx_ext #(.DBIT(7), .OSR(8), .SB_TICK(12), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
      .i_clk(clk), .i_reset(reset), .i_rx(rx[2]), .i_s_tick(s_tick), .o_rx(bus2)
   );

   always #5 clk = ~clk;

   initial begin
      s_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         s_tick = 1'b1;
         @(negedge clk);
         s_tick = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (bus0.o_rx_done_tick === 1'b1) done_cnt[0]++;
      if (bus1.o_rx_done_tick === 1'b1) done_cnt[1]++;
      if (bus2.o_rx_done_tick === 1'b1) done_cnt[2]++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Hold one line level for nt oversampling ticks; returns just after the last tick edge.
   task automatic hold(input int idx, input logic v, input int nt);
      int k;
      rx[idx] = v;
      k = 0;
      while (k < nt) begin
         @(posedge clk);
         #1;
         if (s_tick) k++;
      end
   endtask

   task automatic send_frame(input int idx, input int osr, input int dbit, input logic [8:0] data,
                             input bit par, input logic pbit, input logic stop, input int stop_ticks);
      hold(idx, 1'b0, osr);
      for (int i = 0; i < dbit; i++) hold(idx, data[i], osr);
      if (par) hold(idx, pbit, osr);
      hold(idx, stop, stop_ticks);
   endtask

   // Expected result of one frame from the framing rules alone.
   function automatic exp_t model(input int dbit, input bit par, input bit odd,
                                  input logic [8:0] data, input logic pbit, input logic stop);
      exp_t m;
      logic [8:0] mask;
      int ones;
      mask   = 9'((1 << dbit) - 1);
      m.data = data & mask;
      ones   = $countones(m.data);
      m.perr = par && (((ones + int'(pbit) + int'(odd)) % 2) != 0);
      m.ferr = !stop;
      m.brk  = m.ferr && (m.data == 9'd0) && (!par || !pbit);
      return m;
   endfunction

   task automatic read_out(input int idx, output logic [8:0] d, output logic pe, output logic fe,
                           output logic bk, output logic by);
      case (idx)
         0: begin d = {1'b0, bus0.o_data_out}; pe = bus0.o_parity_err; fe = bus0.o_frame_err;
                  bk = bus0.o_break; by = bus0.o_busy; end
         1: begin d = {1'b0, bus1.o_data_out}; pe = bus1.o_parity_err; fe = bus1.o_frame_err;
                  bk = bus1.o_break; by = bus1.o_busy; end
         default: begin d = {2'b0, bus2.o_data_out}; pe = bus2.o_parity_err; fe = bus2.o_frame_err;
                  bk = bus2.o_break; by = bus2.o_busy; end
      endcase
   endtask

   task automatic check_out(input string tag, input int idx, input exp_t e, input int cnt_exp);
      logic [8:0] d;
      logic pe, fe, bk, by;
      read_out(idx, d, pe, fe, bk, by);
      check({tag, "_data"}, 32'(d), 32'(e.data));
      check({tag, "_perr"}, 32'(pe), 32'(e.perr));
      check({tag, "_ferr"}, 32'(fe), 32'(e.ferr));
      check({tag, "_break"}, 32'(bk), 32'(e.brk));
      check({tag, "_busy"}, 32'(by), 32'd0);
      check({tag, "_dones"}, 32'(done_cnt[idx]), 32'(cnt_exp));
   endtask

   initial begin
      exp_t e, prev;
      int c;
      logic [8:0] d;
      logic pb, st;

      reset = 1'b1;
      rx    = 3'b111;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      e = '0;
      check_out("reset0", 0, e, 0);
      check_out("reset2", 2, e, 0);

      // 8N1 frame 0xA5.
      c = done_cnt[0];
      send_frame(0, 16, 8, 9'h0A5, 0, 1'b0, 1'b1, 16);
      check_out("a5", 0, model(8, 0, 0, 9'h0A5, 1'b0, 1'b1), c + 1);

      // Back-to-back random frames, no idle gap between them.
      for (int i = 0; i < 4; i++) begin
         c = done_cnt[0];
         d = 9'($urandom_range(0, 255));
         send_frame(0, 16, 8, d, 0, 1'b0, 1'b1, 16);
         check_out("b2b", 0, model(8, 0, 0, d, 1'b0, 1'b1), c + 1);
      end

      // Even parity: 0x37 with wrong and with correct parity bit.
      c = done_cnt[1];
      send_frame(1, 16, 8, 9'h037, 1, 1'b0, 1'b1, 16);
      check_out("par0", 1, model(8, 1, 0, 9'h037, 1'b0, 1'b1), c + 1);
      check("par0_flag", 32'(bus1.o_parity_err), 32'd1);
      send_frame(1, 16, 8, 9'h037, 1, 1'b1, 1'b1, 16);
      check_out("par1", 1, model(8, 1, 0, 9'h037, 1'b1, 1'b1), c + 2);
      for (int i = 0; i < 4; i++) begin
         c  = done_cnt[1];
         d  = 9'($urandom_range(0, 255));
         pb = 1'($urandom_range(0, 1));
         st = 1'($urandom_range(0, 1));
         send_frame(1, 16, 8, d, 1, pb, st, 16);
         hold(1, 1'b1, 16);
         check_out("parrnd", 1, model(8, 1, 0, d, pb, st), c + 1);
      end

      // Framing error without break, then a long break.
      c = done_cnt[0];
      send_frame(0, 16, 8, 9'h055, 0, 1'b0, 1'b0, 16);
      hold(0, 1'b1, 16);
      check_out("ferr", 0, model(8, 0, 0, 9'h055, 1'b0, 1'b0), c + 1);
      hold(0, 1'b0, 16 * 12);
      check_out("break", 0, model(8, 0, 0, 9'h000, 1'b0, 1'b0), c + 2);
      hold(0, 1'b1, 16);
      check("break_nofollow", 32'(done_cnt[0]), 32'(c + 2));
      d = 9'($urandom_range(1, 255));
      send_frame(0, 16, 8, d, 0, 1'b0, 1'b1, 16);
      prev = model(8, 0, 0, d, 1'b0, 1'b1);
      check_out("recover", 0, prev, c + 3);

      // False start: line low only 4 ticks.
      c = done_cnt[0];
      hold(0, 1'b0, 4);
      hold(0, 1'b1, 32);
      check_out("falsestart", 0, prev, c);

      // 0x00 frame with a one-tick high glitch on the middle sample of bit 3.
      hold(0, 1'b0, 16);
      for (int i = 0; i < 3; i++) hold(0, 1'b0, 16);
      hold(0, 1'b0, 6);
      hold(0, 1'b1, 1);
      hold(0, 1'b0, 9);
      for (int i = 0; i < 4; i++) hold(0, 1'b0, 16);
      hold(0, 1'b1, 16);
      check_out("glitch", 0, model(8, 0, 0, 9'h000, 1'b0, 1'b1), c + 1);

      // Reset in the middle of a frame.
      c = done_cnt[0];
      hold(0, 1'b0, 16);
      for (int i = 0; i < 3; i++) hold(0, 1'b1, 16);
      check("midframe_busy", 32'(bus0.o_busy), 32'd1);
      reset = 1'b1;
      rx[0] = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check_out("midreset", 0, '0, c);
      hold(0, 1'b1, 32);
      check("midreset_nodone", 32'(done_cnt[0]), 32'(c));
      send_frame(0, 16, 8, 9'h03C, 0, 1'b0, 1'b1, 16);
      check_out("after_rst", 0, model(8, 0, 0, 9'h03C, 1'b0, 1'b1), c + 1);

      // 7-bit, odd parity, OSR 8, 1.5 stop bits.
      c = done_cnt[2];
      send_frame(2, 8, 7, 9'h03C, 1, 1'b1, 1'b1, 12);
      hold(2, 1'b1, 8);
      check_out("d7_3c", 2, model(7, 1, 1, 9'h03C, 1'b1, 1'b1), c + 1);
      for (int i = 0; i < 3; i++) begin
         c  = done_cnt[2];
         d  = 9'($urandom_range(0, 127));
         pb = 1'($urandom_range(0, 1));
         send_frame(2, 8, 7, d, 1, pb, 1'b1, 12);
         hold(2, 1'b1, 8);
         check_out("d7rnd", 2, model(7, 1, 1, d, pb, 1'b1), c + 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
